// File: rtl/sram_port_master.sv
// Request/response front end for a single-port OpenRAM macro: issues registered
// macro accesses, captures read data two edges later and returns it in order.
module sram_port_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                  clk0,
   input  logic                  rstb0,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  csb0,
   output logic                  web0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);

   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      fifo_cnt;
   logic [CNT_W-1:0]      credit_cnt;
   logic [CNT_W-1:0]      credit_next;
   logic                  tag_issue;
   logic                  tag_capture;
   logic                  accept;
   logic                  push;
   logic                  pop;

   assign accept    = req_valid && req_ready;
   assign push      = tag_capture;
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_valid = (fifo_cnt != '0);
   assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : '0;

   // Credits count reads from acceptance until their response is popped, so the
   // hand-off from the tag pipe into the FIFO leaves the count unchanged.
   always_comb begin
      credit_next = credit_cnt;
      if (accept && !req_we)
         credit_next = credit_next + CNT_W'(1);
      if (pop)
         credit_next = credit_next - CNT_W'(1);
   end

   always_ff @(posedge clk0) begin
      if (!rstb0) begin
         csb0        <= 1'b1;
         web0        <= 1'b1;
         addr0       <= '0;
         din0        <= '0;
         req_ready   <= 1'b0;
         tag_issue   <= 1'b0;
         tag_capture <= 1'b0;
         credit_cnt  <= '0;
         fifo_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         csb0 <= !accept;
         web0 <= !(accept && req_we);
         if (accept) begin
            addr0 <= req_addr;
            din0  <= req_wdata;
         end
         tag_issue   <= accept && !req_we;
         tag_capture <= tag_issue;
         credit_cnt  <= credit_next;
         req_ready   <= (credit_next < CNT_W'(RSP_DEPTH));
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            fifo_cnt <= fifo_cnt + CNT_W'(1);
         else if (!push && pop)
            fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk0) begin
      if (rstb0 && push)
         fifo_mem[wr_ptr] <= dout0;
   end

endmodule

// File: tb/tb_sram_port_master.sv
// Self-checking bench for sram_port_master with a behavioural OpenRAM macro and
// an in-order scoreboard of expected read data.
module tb_sram_port_master;

   localparam int DW = 32;
   localparam int AW = 7;

   logic          clk0 = 1'b0;
   logic          rstb0;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          csb0;
   logic          web0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout0;

   logic [DW-1:0] sram    [1 << AW];
   logic [DW-1:0] ref_mem [1 << AW];
   logic [DW-1:0] exp_q [$];
   int            rsp_cycles [$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int accept_cnt = 0;
   int rsp_cnt = 0;
   int stall_cnt = 0;
   int last_accept_cyc = 0;
   int base_acc;
   int base_rsp;

   sram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(4)) dut (
      .clk0(clk0), .rstb0(rstb0),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
   );

   always #5 clk0 = ~clk0;

   always @(posedge clk0) cyc <= cyc + 1;

   // Macro model: registered inputs sampled on the edge, read data valid the cycle after.
   always @(posedge clk0) begin
      if (!csb0) begin
         if (!web0)
            sram[addr0] <= din0;
         else
            dout0 <= sram[addr0];
      end
   end

   task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Handshakes are predicted mid-cycle, where inputs and registered outputs are stable.
   always @(negedge clk0) begin
      if (rstb0 === 1'b1) begin
         if (req_valid && req_ready) begin
            accept_cnt++;
            if (req_we)
               ref_mem[req_addr] = req_wdata;
            else
               exp_q.push_back(ref_mem[req_addr]);
         end
         if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            rsp_cycles.push_back(cyc);
            if (exp_q.size() == 0)
               checkOutput("rsp_without_request", 32'(exp_q.size()), 32'd1);
            else
               checkOutput("rsp_rdata", rsp_rdata, exp_q.pop_front());
         end
      end
   end

   task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int waited = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = data;
      while (!req_ready && waited < 50) begin
         @(posedge clk0); #1;
         waited++;
         stall_cnt++;
      end
      if (!req_ready) begin
         checkOutput("req_accept_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
      end else begin
         @(posedge clk0); #1;
         last_accept_cyc = cyc;
      end
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk0); #1;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstb0     = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;

      // Reset held with a pending request: nothing may be issued or accepted.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk0); #1;
         checkOutput("rst_csb0", 32'(csb0), 32'd1);
         checkOutput("rst_web0", 32'(web0), 32'd1);
         checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
         checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      checkOutput("rst_addr0", 32'(addr0), 32'd0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
      rstb0 = 1'b1;
      idle();
      checkOutput("release_req_ready_low", 32'(req_ready), 32'd0);
      @(posedge clk0); #1;
      checkOutput("release_req_ready_high", 32'(req_ready), 32'd1);

      // Write then read-after-write with two-cycle latency.
      rsp_ready = 1'b1;
      base_rsp = rsp_cnt;
      rsp_cycles.delete();
      applyStimulus(1'b1, 7'h05, 32'hDEADBEEF);
      applyStimulus(1'b0, 7'h05, 32'h0);
      idle();
      waitCycles(6);
      checkOutput("t2_rsp_count", 32'(rsp_cnt - base_rsp), 32'd1);
      if (rsp_cycles.size() > 0)
         checkOutput("t2_latency", 32'(rsp_cycles[0] - last_accept_cyc), 32'd2);

      // Full-throughput streaming.
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, 7'(8'h10 + i), 32'(i + 1));
      stall_cnt = 0;
      base_rsp = rsp_cnt;
      rsp_cycles.delete();
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b0, 7'(8'h10 + i), 32'h0);
      idle();
      waitCycles(6);
      checkOutput("t3_stalls", 32'(stall_cnt), 32'd0);
      checkOutput("t3_rsp_count", 32'(rsp_cnt - base_rsp), 32'd8);
      for (int i = 1; i < rsp_cycles.size(); i++)
         checkOutput("t3_consecutive", 32'(rsp_cycles[i] - rsp_cycles[i-1]), 32'd1);

      // Backpressure: credits stop acceptance at four outstanding reads.
      rsp_ready = 1'b0;
      base_acc = accept_cnt;
      base_rsp = rsp_cnt;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = 7'(8'h10 + i);
         @(posedge clk0); #1;
      end
      checkOutput("t4_accepted", 32'(accept_cnt - base_acc), 32'd4);
      checkOutput("t4_req_ready", 32'(req_ready), 32'd0);
      checkOutput("t4_csb0_idle", 32'(csb0), 32'd1);
      checkOutput("t4_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t4_rsp_hold", rsp_rdata, 32'h1);
      rsp_ready = 1'b1;
      waitCycles(12);
      idle();
      waitCycles(8);
      checkOutput("t4_resumed", 32'(accept_cnt - base_acc > 4), 32'd1);
      checkOutput("t4_no_loss", 32'(rsp_cnt - base_rsp), 32'(accept_cnt - base_acc));
      checkOutput("t4_queue_empty", 32'(exp_q.size()), 32'd0);

      // Address extremes pass through unchanged.
      base_rsp = rsp_cnt;
      applyStimulus(1'b1, 7'h7F, 32'hA5A5A5A5);
      applyStimulus(1'b1, 7'h00, 32'h5A5A5A5A);
      applyStimulus(1'b0, 7'h7F, 32'h0);
      applyStimulus(1'b0, 7'h00, 32'h0);
      idle();
      waitCycles(6);
      checkOutput("t5_rsp_count", 32'(rsp_cnt - base_rsp), 32'd2);

      // Reset with two reads in flight and two buffered: nothing stale survives.
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 7'(8'h10 + i), 32'h0);
      idle();
      checkOutput("t6_buffered", 32'(rsp_valid), 32'd1);
      rstb0 = 1'b0;
      exp_q.delete();
      @(posedge clk0); #1;
      checkOutput("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("t6_rst_req_ready", 32'(req_ready), 32'd0);
      rstb0 = 1'b1;
      rsp_ready = 1'b1;
      base_rsp = rsp_cnt;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk0); #1;
         checkOutput("t6_no_stale", 32'(rsp_valid), 32'd0);
      end
      applyStimulus(1'b0, 7'h05, 32'h0);
      idle();
      waitCycles(6);
      checkOutput("t6_fresh_count", 32'(rsp_cnt - base_rsp), 32'd1);
      checkOutput("t6_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
